// File: rtl/rx_deserializer.sv
// UART RX deserializer: start/data/[parity]/stop shifter with a one-deep output buffer.
// Optional even-parity checking is compiled in with `define RX_PARITY_EN.
module rx_deserializer #(
  parameter int SIZE = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_rxd,
  input  logic            i_rxen,
  input  logic            i_bit_stb,
  output logic [SIZE-1:0] o_data_out,
  output logic            o_data_valid,
  input  logic            i_data_ready,
  output logic            o_frame_err,
  output logic            o_parity_err,
  output logic            o_overrun,
  output logic            o_rxrdy
);

  localparam int CW = $clog2(SIZE) + 1;

`ifdef RX_PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_STOP   = 2'd2,
    S_PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;
`endif

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_shift;
  logic [CW-1:0]   r_bit_cnt;
  logic            w_stb;
  logic            w_last;
  logic            w_start;
  logic            w_shift;
  logic            w_par_ld;
  logic            w_load;
  logic            w_xfer;
  logic            w_par_err;

  logic [SIZE-1:0] r_data;
  logic            r_valid;
  logic            r_ferr;
  logic            r_perr;
  logic            r_ovr;

  assign w_stb  = i_bit_stb & i_rxen;
  assign w_last = (r_bit_cnt == CW'(SIZE - 1));
  assign w_xfer = r_valid & i_data_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Any non-IDLE state drops the partial frame when RXEN falls.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_stb && !i_rxd) w_next = S_DATA;
      end
      S_DATA: begin
        if (!i_rxen) w_next = S_IDLE;
`ifdef RX_PARITY_EN
        else if (i_bit_stb && w_last) w_next = S_PARITY;
`else
        else if (i_bit_stb && w_last) w_next = S_STOP;
`endif
      end
`ifdef RX_PARITY_EN
      S_PARITY: begin
        if (!i_rxen)        w_next = S_IDLE;
        else if (i_bit_stb) w_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (!i_rxen)        w_next = S_IDLE;
        else if (i_bit_stb) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_shift  = 1'b0;
    w_par_ld = 1'b0;
    w_load   = 1'b0;
    unique case (r_state)
      S_IDLE:   w_start  = w_stb & ~i_rxd;
      S_DATA:   w_shift  = w_stb;
`ifdef RX_PARITY_EN
      S_PARITY: w_par_ld = w_stb;
`endif
      S_STOP:   w_load   = w_stb;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
    end else if (w_shift) begin
      r_shift   <= {i_rxd, r_shift[SIZE-1:1]};
      r_bit_cnt <= r_bit_cnt + CW'(1);
    end
  end

`ifdef RX_PARITY_EN
  logic r_par_err;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         r_par_err <= 1'b0;
    else if (w_par_ld) r_par_err <= (^r_shift) ^ i_rxd;
  end
  assign w_par_err = r_par_err;
`else
  assign w_par_err = 1'b0;
`endif

  // Load wins over transfer; overrun only when an unread word is lost.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (w_load) begin
      r_data  <= r_shift;
      r_valid <= 1'b1;
      r_ferr  <= ~i_rxd;
      r_perr  <= w_par_err;
      r_ovr   <= r_valid & ~w_xfer;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end
  end

  assign o_data_out   = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_ferr;
  assign o_parity_err = r_perr;
  assign o_overrun    = r_ovr;
  assign o_rxrdy      = r_valid;

endmodule

// File: tb/tb_rx_deserializer.sv
// Scoreboard bench for rx_deserializer (SIZE=8).
// Parity scenarios are built only when RX_PARITY_EN is defined.
module tb_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       rxen;
  logic       stb;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       ferr;
  logic       perr;
  logic       ovr;
  logic       rxrdy;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
  } word_t;

  word_t sb[$];
  word_t exp_w;
  word_t got_w;
  int    n_checks = 0;
  int    n_pass   = 0;

  rx_deserializer #(.SIZE(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rxd        (rxd),
    .i_rxen       (rxen),
    .i_bit_stb    (stb),
    .o_data_out   (data_out),
    .o_data_valid (valid),
    .i_data_ready (ready),
    .o_frame_err  (ferr),
    .o_parity_err (perr),
    .o_overrun    (ovr),
    .o_rxrdy      (rxrdy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; strobe covers exactly the next posedge.
  task automatic strobe(input logic b);
    rxd = b;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic par, input int gap,
                            input logic rdy_stop, input logic ov);
    word_t e;
    strobe(1'b0);
    repeat (gap) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      strobe(d[i]);
      repeat (gap) @(negedge clk);
    end
`ifdef RX_PARITY_EN
    strobe(par);
    repeat (gap) @(negedge clk);
    e.pe = par ^ (^d);
`else
    e.pe = 1'b0;
    if (par) e.pe = 1'b0;
`endif
    e.data = d;
    e.fe   = ~stop;
    e.ov   = ov;
    sb.push_back(e);
    ready = rdy_stop;
    strobe(stop);
    ready = 1'b0;
    rxd   = 1'b1;
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rxd = 1'b1; rxen = 1'b0; stb = 1'b0; ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({data_out, valid, ferr, perr, ovr, rxrdy} !== 13'd0)
      $display("FAIL reset_outputs got=%h exp=0",
               {data_out, valid, ferr, perr, ovr, rxrdy});
    else n_pass++;
    rst = 1'b0;
    rxen = 1'b1;
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL reset_idle valid=%b exp=0", valid);
    else n_pass++;
  endtask

  task automatic test_nominal();
    send_frame(8'hA5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    n_checks++;
    if (valid !== 1'b1 || rxrdy !== 1'b1)
      $display("FAIL nominal_valid valid=%b rxrdy=%b exp=1", valid, rxrdy);
    else n_pass++;
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (got_w !== exp_w)
      $display("FAIL nominal_word got=%h exp=%h", got_w, exp_w);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || data_out !== 8'hA5)
      $display("FAIL nominal_hold valid=%b data=%h exp=1/a5", valid, data_out);
    else n_pass++;
    accept();
    n_checks++;
    if (valid !== 1'b0 || rxrdy !== 1'b0)
      $display("FAIL nominal_accept valid=%b rxrdy=%b exp=0", valid, rxrdy);
    else n_pass++;
  endtask

  task automatic test_frame_err();
    send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (valid !== 1'b1 || got_w !== exp_w)
      $display("FAIL frame_err_word valid=%b got=%h exp=%h", valid, got_w, exp_w);
    else n_pass++;
    accept();
    n_checks++;
    if (valid !== 1'b0) $display("FAIL frame_err_drop valid=%b exp=0", valid);
    else n_pass++;
  endtask

  task automatic test_overrun();
    send_frame(8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (got_w !== exp_w)
      $display("FAIL overrun_first got=%h exp=%h", got_w, exp_w);
    else n_pass++;
    send_frame(8'hC3, 1'b1, 1'b0, 1, 1'b0, 1'b1);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (valid !== 1'b1 || got_w !== exp_w)
      $display("FAIL overrun_second valid=%b got=%h exp=%h", valid, got_w, exp_w);
    else n_pass++;
    accept();
    n_checks++;
    if (valid !== 1'b0 || ovr !== 1'b0)
      $display("FAIL overrun_clear valid=%b ovr=%b exp=0/0", valid, ovr);
    else n_pass++;
  endtask

  task automatic test_abort_false_start();
    strobe(1'b1);
    repeat (4) @(negedge clk);
    rxen = 1'b0;
    strobe(1'b0);
    repeat (2) @(negedge clk);
    rxen = 1'b1;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL false_start valid=%b exp=0", valid);
    else n_pass++;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    rxen = 1'b0;
    @(negedge clk);
    rxen = 1'b1;
    send_frame(8'h0F, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (valid !== 1'b1 || got_w !== exp_w)
      $display("FAIL abort_word valid=%b got=%h exp=%h", valid, got_w, exp_w);
    else n_pass++;
    accept();
    repeat (12) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0) $display("FAIL abort_single valid=%b exp=0", valid);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    strobe(1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (valid !== 1'b0) $display("FAIL midreset_valid valid=%b exp=0", valid);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    send_frame(8'h81, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (valid !== 1'b1 || got_w !== exp_w)
      $display("FAIL midreset_word valid=%b got=%h exp=%h", valid, got_w, exp_w);
    else n_pass++;
    accept();
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'hA5, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (got_w !== exp_w) $display("FAIL parity_ok got=%h exp=%h", got_w, exp_w);
    else n_pass++;
    accept();
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (got_w !== exp_w) $display("FAIL parity_bad got=%h exp=%h", got_w, exp_w);
    else n_pass++;
    accept();
  endtask
`endif

  task automatic test_back_to_back();
    send_frame(8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (got_w !== exp_w) $display("FAIL b2b_first got=%h exp=%h", got_w, exp_w);
    else n_pass++;
    send_frame(8'h96, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    exp_w = sb.pop_front();
    got_w = {data_out, ferr, perr, ovr};
    n_checks++;
    if (valid !== 1'b1 || got_w !== exp_w)
      $display("FAIL b2b_load_accept valid=%b got=%h exp=%h", valid, got_w, exp_w);
    else n_pass++;
    accept();
    n_checks++;
    if (valid !== 1'b0) $display("FAIL b2b_drain valid=%b exp=0", valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_frame_err();
    test_overrun();
    test_abort_false_start();
    test_reset_mid_frame();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover size=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
